// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM configuration-update slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default datapath widths and the update FSM state encoding.
package pwm_pkg;

    localparam int DW_DEF    = 16;
    localparam int FW_DEF    = 8;
    localparam int CNT_W_DEF = 8;

    // Update FSM encoding; kept as plain constants so older tools and
    // waveform scripts that decode the raw 2-bit value keep working.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;

endpackage

// File: rtl/pwm_wrap_det.sv
// Counter period-boundary detector: flags the first cycle the counter sits on its wrap value.
// Latency: combinational on count_val_i against a one-cycle-old copy of it; pulse lasts 1 cycle.
// Backpressure: none; the pulse is always produced and never held.
// Ports: clk/rst_n; count_val_i live count; period_act_i active period;
//        upnotdown_i direction (1 = up); wrap_o 1-cycle boundary pulse.
module pwm_wrap_det #(
    parameter int DW = pwm_pkg::DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] count_val_i,
    input  logic [DW-1:0] period_act_i,
    input  logic          upnotdown_i,
    output logic          wrap_o
);

    logic [DW-1:0] count_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_prev_q <= '0;
        end else begin
            count_prev_q <= count_val_i;
        end
    end

    // Requiring a change since last cycle means a prescaled counter that holds
    // its wrap value for several cycles only produces one pulse.
    always_comb begin
        wrap_o = (count_val_i != count_prev_q) &&
                 (upnotdown_i ? (count_val_i == '0) : (count_val_i == period_act_i));
    end

endmodule

// File: rtl/pwm_update_ctrl.sv
// Atomic PWM configuration commit: shadows register values and applies them as one set at a period boundary.
// Latency: upd_req+upd_now -> *_act after 2 cycles; boundary commit -> *_act 2 cycles after count hits wrap value.
// Backpressure: none; a newer upd_req while waiting replaces the held snapshot (latest wins).
// Ports: *_in register values, upd_req/upd_now request, count_val/en/upnotdown counter status;
//        *_act active config, upd_pending waiting flag, upd_done commit pulse, commit_cnt commit count.
module pwm_update_ctrl
    import pwm_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int FW    = FW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    period_in,
    input  logic [DW-1:0]    compare1_in,
    input  logic [DW-1:0]    compare2_in,
    input  logic [FW-1:0]    functions_in,
    input  logic             pwm_en_in,
    input  logic             upd_req,
    input  logic             upd_now,
    input  logic [DW-1:0]    count_val,
    input  logic             en,
    input  logic             upnotdown,
    output logic [DW-1:0]    period_act,
    output logic [DW-1:0]    compare1_act,
    output logic [DW-1:0]    compare2_act,
    output logic [FW-1:0]    functions_act,
    output logic             pwm_en_act,
    output logic             upd_pending,
    output logic             upd_done,
    output logic [CNT_W-1:0] commit_cnt
);

    logic [1:0]       state_q, state_d;
    logic             wrap;
    logic             commit;

    logic [DW-1:0]    snap_period_q, snap_cmp1_q, snap_cmp2_q;
    logic [FW-1:0]    snap_func_q;
    logic             snap_pwm_en_q;

    logic [DW-1:0]    period_q, cmp1_q, cmp2_q;
    logic [FW-1:0]    func_q;
    logic             pwm_en_q, pwm_en_d;
    logic             upd_done_q;
    logic [CNT_W-1:0] commit_cnt_q;

    pwm_wrap_det #(.DW(DW)) u_wrap_det (
        .clk          (clk),
        .rst_n        (rst_n),
        .count_val_i  (count_val),
        .period_act_i (period_q),
        .upnotdown_i  (upnotdown),
        .wrap_o       (wrap)
    );

    assign commit = (state_q == ST_COMMIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A stopped counter never reaches a boundary, so commit straight away.
                if (upd_req) begin
                    state_d = (upd_now || !en) ? ST_COMMIT : ST_PENDING;
                end
            end
            ST_PENDING: begin
                // A request arriving with the wrap still commits: the snapshot
                // taken on this edge is the one the COMMIT cycle applies.
                if ((upd_req && upd_now) || wrap || !en) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = upd_req ? ST_PENDING : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Enable only rises through a commit, but a cleared register enable
    // shuts the output off at once regardless of update state.
    always_comb begin
        pwm_en_d = pwm_en_q;
        if (commit) begin
            pwm_en_d = snap_pwm_en_q;
        end
        if (!pwm_en_in) begin
            pwm_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_period_q <= '0;
            snap_cmp1_q   <= '0;
            snap_cmp2_q   <= '0;
            snap_func_q   <= '0;
            snap_pwm_en_q <= 1'b0;
        end else if (upd_req) begin
            snap_period_q <= period_in;
            snap_cmp1_q   <= compare1_in;
            snap_cmp2_q   <= compare2_in;
            snap_func_q   <= functions_in;
            snap_pwm_en_q <= pwm_en_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            period_q     <= '0;
            cmp1_q       <= '0;
            cmp2_q       <= '0;
            func_q       <= '0;
            pwm_en_q     <= 1'b0;
            upd_done_q   <= 1'b0;
            commit_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pwm_en_q   <= pwm_en_d;
            upd_done_q <= commit;
            if (commit) begin
                period_q     <= snap_period_q;
                cmp1_q       <= snap_cmp1_q;
                cmp2_q       <= snap_cmp2_q;
                func_q       <= snap_func_q;
                commit_cnt_q <= commit_cnt_q + CNT_W'(1);
            end
        end
    end

    assign period_act    = period_q;
    assign compare1_act  = cmp1_q;
    assign compare2_act  = cmp2_q;
    assign functions_act = func_q;
    assign pwm_en_act    = pwm_en_q;
    assign upd_pending   = (state_q == ST_PENDING);
    assign upd_done      = upd_done_q;
    assign commit_cnt    = commit_cnt_q;

endmodule

// File: tb/tb_pwm_update_ctrl.sv
module tb_pwm_update_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] period_in = '0, compare1_in = '0, compare2_in = '0;
    logic [7:0]  functions_in = '0;
    logic        pwm_en_in = 1'b0, upd_req = 1'b0, upd_now = 1'b0;
    logic [15:0] count_val = '0;
    logic        en = 1'b0, upnotdown = 1'b1;
    logic [15:0] period_act, compare1_act, compare2_act;
    logic [7:0]  functions_act;
    logic        pwm_en_act, upd_pending, upd_done;
    logic [7:0]  commit_cnt;

    int errors = 0;
    int checks = 0;

    // Bench-side counter stimulus settings.
    logic [15:0] per = 16'd9;
    int          presc = 1;
    int          presc_cnt = 0;

    pwm_update_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .period_in     (period_in),
        .compare1_in   (compare1_in),
        .compare2_in   (compare2_in),
        .functions_in  (functions_in),
        .pwm_en_in     (pwm_en_in),
        .upd_req       (upd_req),
        .upd_now       (upd_now),
        .count_val     (count_val),
        .en            (en),
        .upnotdown     (upnotdown),
        .period_act    (period_act),
        .compare1_act  (compare1_act),
        .compare2_act  (compare2_act),
        .functions_act (functions_act),
        .pwm_en_act    (pwm_en_act),
        .upd_pending   (upd_pending),
        .upd_done      (upd_done),
        .commit_cnt    (commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks "a commit is due on the next edge" and "a snapshot is waiting"
    // as booleans, derived directly from the commit rules.
    logic [15:0] m_per = '0, m_c1 = '0, m_c2 = '0, m_prev = '0;
    logic [7:0]  m_fn = '0, m_cnt = '0;
    logic        m_en = 0, m_pend = 0, m_due = 0, m_done = 0;
    logic [15:0] s_per = '0, s_c1 = '0, s_c2 = '0;
    logic [7:0]  s_fn = '0;
    logic        s_en = 0;

    always @(posedge clk or negedge rst_n) begin
        logic wrap_m, was_due, was_pend;
        if (!rst_n) begin
            m_per = '0; m_c1 = '0; m_c2 = '0; m_fn = '0; m_en = 0;
            m_pend = 0; m_due = 0; m_done = 0; m_cnt = '0; m_prev = '0;
            s_per = '0; s_c1 = '0; s_c2 = '0; s_fn = '0; s_en = 0;
        end else begin
            wrap_m = (count_val != m_prev) &&
                     (upnotdown ? (count_val == 16'd0) : (count_val == m_per));
            m_prev = count_val;
            was_due = m_due;
            was_pend = m_pend;
            m_done = was_due;
            if (was_due) begin
                m_per = s_per; m_c1 = s_c1; m_c2 = s_c2; m_fn = s_fn;
                m_en = s_en;
                m_cnt = m_cnt + 8'd1;
            end
            if (!pwm_en_in) m_en = 0;
            m_due = 0;
            m_pend = was_pend;
            if (was_due) begin
                m_pend = upd_req;
            end else if (upd_req) begin
                if (upd_now || !en || (was_pend && wrap_m)) begin
                    m_due = 1; m_pend = 0;
                end else begin
                    m_pend = 1;
                end
            end else if (was_pend && (wrap_m || !en)) begin
                m_due = 1; m_pend = 0;
            end
            if (upd_req) begin
                s_per = period_in; s_c1 = compare1_in; s_c2 = compare2_in;
                s_fn = functions_in; s_en = pwm_en_in;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("m_period",   {16'd0, period_act},   {16'd0, m_per});
        chk("m_cmp1",     {16'd0, compare1_act}, {16'd0, m_c1});
        chk("m_cmp2",     {16'd0, compare2_act}, {16'd0, m_c2});
        chk("m_func",     {24'd0, functions_act}, {24'd0, m_fn});
        chk("m_pwm_en",   {31'd0, pwm_en_act},   {31'd0, m_en});
        chk("m_pending",  {31'd0, upd_pending},  {31'd0, m_pend});
        chk("m_done",     {31'd0, upd_done},     {31'd0, m_done});
        chk("m_cnt",      {24'd0, commit_cnt},   {24'd0, m_cnt});
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
        if (en) begin
            presc_cnt++;
            if (presc_cnt >= presc) begin
                presc_cnt = 0;
                if (upnotdown) count_val = (count_val >= per) ? 16'd0 : count_val + 16'd1;
                else           count_val = (count_val == 16'd0) ? per : count_val - 16'd1;
            end
        end
    endtask

    task automatic pulse_req();
        upd_req = 1'b1;
        cycle();
        upd_req = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int maxc);
        bit got = 0;
        for (int k = 0; k < maxc; k++) begin
            cycle();
            if (upd_done) begin
                got = 1;
                break;
            end
        end
        chk(nm, {31'd0, got}, 32'd1);
    endtask

    task automatic wait_count(input string nm, input logic [15:0] v, input int maxc);
        bit got = 0;
        for (int k = 0; k < maxc; k++) begin
            cycle();
            if (count_val == v) begin
                got = 1;
                break;
            end
        end
        chk(nm, {31'd0, got}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int z;
        bit req_sent;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_period",  {16'd0, period_act}, 32'd0);
        chk("rst_pwm_en",  {31'd0, pwm_en_act}, 32'd0);
        chk("rst_pending", {31'd0, upd_pending}, 32'd0);
        chk("rst_cnt",     {24'd0, commit_cnt}, 32'd0);
        rst_n = 1'b1;
        cycle();

        // 1: immediate commit with the counter stopped
        en = 0; period_in = 16'd100; compare1_in = 16'd40; compare2_in = 16'd50;
        functions_in = 8'hA5; pwm_en_in = 1;
        pulse_req();
        chk("t1_not_yet", {16'd0, period_act}, 32'd0);
        cycle();
        chk("t1_period", {16'd0, period_act}, 32'd100);
        chk("t1_cmp1",   {16'd0, compare1_act}, 32'd40);
        chk("t1_func",   {24'd0, functions_act}, 32'hA5);
        chk("t1_done",   {31'd0, upd_done}, 32'd1);
        chk("t1_cnt",    {24'd0, commit_cnt}, 32'd1);
        chk("t1_pwm_en", {31'd0, pwm_en_act}, 32'd1);

        // 2: boundary commit while counting up 0..9
        period_in = 16'd9;
        pulse_req();
        cycle();
        chk("t2_setup_period", {16'd0, period_act}, 32'd9);
        per = 16'd9; presc = 1; presc_cnt = 0; upnotdown = 1; count_val = 16'd0; en = 1;
        z = -1; req_sent = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (z >= 0 && i == z + 1) chk("t2_hold_cmp1", {16'd0, compare1_act}, 32'd40);
            if (z >= 0 && i == z + 2) begin
                chk("t2_cmp1", {16'd0, compare1_act}, 32'd7);
                chk("t2_done", {31'd0, upd_done}, 32'd1);
                break;
            end
            if (req_sent && z < 0 && count_val == 16'd0) begin
                z = i;
                chk("t2_pending_at_wrap", {31'd0, upd_pending}, 32'd1);
                chk("t2_cmp1_early", {16'd0, compare1_act}, 32'd40);
            end
            if (!req_sent && count_val == 16'd3) begin
                compare1_in = 16'd7; upd_req = 1; req_sent = 1;
            end else begin
                upd_req = 0;
            end
        end
        upd_req = 0;
        chk("t2_wrap_seen", {31'd0, (z >= 0)}, 32'd1);
        chk("t2_cnt", {24'd0, commit_cnt}, 32'd3);

        // 3: byte-wise torn write, two requests before one boundary
        wait_count("t3_sync", 16'd1, 20);
        period_in = 16'h0034;
        pulse_req();
        cycle();
        period_in = 16'h1234;
        pulse_req();
        chk("t3_pending", {31'd0, upd_pending}, 32'd1);
        wait_done("t3_commit", 30);
        chk("t3_period", {16'd0, period_act}, 32'h1234);
        chk("t3_cnt", {24'd0, commit_cnt}, 32'd4);
        repeat (12) cycle();
        chk("t3_single", {24'd0, commit_cnt}, 32'd4);

        // 4: down count, prescale 4, wrap on 0 -> period
        en = 0; upnotdown = 0; presc = 4; presc_cnt = 0; per = 16'd5;
        period_in = 16'd5; compare2_in = 16'd0;
        pulse_req();
        cycle();
        chk("t4_setup_period", {16'd0, period_act}, 32'd5);
        count_val = 16'd5;
        cycle(); cycle();
        en = 1;
        compare2_in = 16'd3;
        pulse_req();
        wait_done("t4_commit_a", 40);
        chk("t4_cmp2_a", {16'd0, compare2_act}, 32'd3);
        chk("t4_cnt_a", {24'd0, commit_cnt}, 32'd6);
        chk("t4_at_top", {16'd0, count_val}, 32'd5);
        compare2_in = 16'd4;
        pulse_req();
        wait_done("t4_commit_b", 40);
        chk("t4_cmp2_b", {16'd0, compare2_act}, 32'd4);
        repeat (30) cycle();
        chk("t4_cnt_b", {24'd0, commit_cnt}, 32'd7);

        // 5: safety disable while pending
        wait_count("t5_sync", 16'd4, 60);
        compare1_in = 16'd11;
        pulse_req();
        chk("t5_pending", {31'd0, upd_pending}, 32'd1);
        pwm_en_in = 0;
        cycle();
        chk("t5_en_off", {31'd0, pwm_en_act}, 32'd0);
        chk("t5_still_pending", {31'd0, upd_pending}, 32'd1);
        chk("t5_no_done", {31'd0, upd_done}, 32'd0);
        pwm_en_in = 1;
        cycle();
        chk("t5_no_rise", {31'd0, pwm_en_act}, 32'd0);
        wait_done("t5_commit", 40);
        chk("t5_en_on", {31'd0, pwm_en_act}, 32'd1);
        chk("t5_cmp1", {16'd0, compare1_act}, 32'd11);
        chk("t5_cnt", {24'd0, commit_cnt}, 32'd8);

        // 6: asynchronous reset while pending
        wait_count("t6_sync", 16'd4, 60);
        compare1_in = 16'd22;
        pulse_req();
        chk("t6_pending", {31'd0, upd_pending}, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("t6_period", {16'd0, period_act}, 32'd0);
        chk("t6_cmp1",   {16'd0, compare1_act}, 32'd0);
        chk("t6_cmp2",   {16'd0, compare2_act}, 32'd0);
        chk("t6_func",   {24'd0, functions_act}, 32'd0);
        chk("t6_pwm_en", {31'd0, pwm_en_act}, 32'd0);
        chk("t6_pend",   {31'd0, upd_pending}, 32'd0);
        chk("t6_cnt",    {24'd0, commit_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (40) cycle();
        chk("t6_no_commit", {24'd0, commit_cnt}, 32'd0);
        chk("t6_cmp1_zero", {16'd0, compare1_act}, 32'd0);

        // commit_cnt wraps modulo 256
        en = 0;
        for (int n = 0; n < 257; n++) begin
            pulse_req();
            cycle();
        end
        chk("cnt_wrap", {24'd0, commit_cnt}, 32'd1);

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
